urv_writeback: RTL and testbench
================================

// Module: urv_writeback
// PURPOSE
//  Writeback stage of the uRV pipeline: producer side of the register-file write/bypass interface.
//  Registers the instruction leaving execute and aligns/sign-extends load data from the data bus.
//  Holds the pipeline while a load is outstanding, then drives the rd write and W-stage bypass ports.
// PARAMETERS
//  (none)
// PORTS
//  clk_i               in   1   clock; all state updates on rising edge
//  rst_i               in   1   synchronous reset, active-high
//  x_valid_i           in   1   execute stage presents an instruction this cycle
//  x_rd_i              in   5   destination register index
//  x_rd_value_i        in   32  execute result (non-load)
//  x_rd_write_i        in   1   instruction writes rd
//  x_load_i            in   1   instruction is a load
//  x_fun_i             in   3   load funct3 (LB/LH/LW/LBU/LHU)
//  x_dm_addr_i         in   2   low bits of load address
//  dm_data_l_i         in   32  raw load word from data memory
//  dm_load_done_i      in   1   load data valid this cycle
//  w_rd_o              out  5   rd index to regfile
//  w_rd_value_o        out  32  rd value to regfile
//  w_rd_store_o        out  1   regfile write strobe
//  w_bypass_rd_write_o out  1   W-stage bypass valid
//  w_bypass_rd_value_o out  32  W-stage bypass value
//  w_stall_req_o       out  1   stall fetch/decode/execute
//  w_instret_o         out  64  retired-instruction count (see CONFIGURATION)
// BEHAVIOUR
//  - FSM: IDLE (no valid instr in W), EXEC (valid non-load), LOAD_WAIT (valid load, data not yet seen).
//  - Capture: at edge with w_stall_req_o=0, W regs <= x_* inputs; state <= IDLE if !x_valid_i,
//    LOAD_WAIT if x_load_i, else EXEC. Latency execute->regfile write: 1 cycle (non-load).
//  - With w_stall_req_o=1, W regs hold; x_* inputs ignored (upstream is frozen).
//  - EXEC: w_rd_store_o = rd_write && rd!=0; value = captured x_rd_value.
//  - LOAD_WAIT: w_stall_req_o = !dm_load_done_i. In the cycle dm_load_done_i=1: stall low,
//    w_rd_store_o = rd_write && rd!=0, value = aligned load data, next capture same edge.
//    dm_load_done_i outside LOAD_WAIT is ignored. No timeout; waits indefinitely.
//  - Alignment: LB/LBU select byte addr[1:0] (0 = bits 7:0); LH/LHU select half addr[1] (0 = 15:0);
//    LB/LH sign-extend, LBU/LHU zero-extend; LW and funct3 011/110/111 pass raw word.
//    Misaligned LH/LW (addr[0]=1 or addr!=0): no trap; address bits beyond selection ignored.
//  - Bypass outputs equal store outputs each cycle (w_bypass_rd_write_o == w_rd_store_o).
//  - w_rd_o always = captured rd, even when not storing.
//  - rd==0: never asserts store/bypass strobes.
//  - Reset: state <= IDLE, W regs cleared (rd=0, value=0). While rst_i=1 all strobes and
//    w_stall_req_o forced 0 combinationally; reset during LOAD_WAIT abandons the load, no write.
//  - Reset values: w_rd_o=0, w_rd_value_o=0, strobes=0, w_stall_req_o=0, w_instret_o=0.
// CONFIGURATION
//  URV_WB_INSTRET_EN defined: 64-bit counter, +1 on each retire (EXEC edge, or LOAD_WAIT edge
//  with dm_load_done_i=1), counts rd==0 / no-write instrs too; wraps 2^64-1 -> 0; cleared by reset.
//  Undefined: no counter logic; w_instret_o tied to 0.
// TESTING
//  - ALU: x_valid=1, rd=5, value=0x12345678, rd_write=1 -> next cycle store=1, rd=5, value=0x12345678.
//  - LB sign: rd=3, fun=000, addr=2'b11, data=0x80FF_0000, done in W cycle -> value=0xFFFFFF80, no stall.
//  - LHU wait: fun=101, addr=2, data=0xBEEF_1234, done after 3 cycles -> stall=1 for 3 cycles,
//    then store with value=0x0000BEEF; x_* during stall not captured.
//  - rd=0 ALU and rd=0 load -> store/bypass never asserted; load still stalls until done.
//  - Reset mid-LOAD_WAIT: rst_i=1 one cycle -> stall=0 immediately, no store, later done ignored.
//  - URV_WB_INSTRET_EN: 10 mixed instrs incl. 2 loads -> w_instret_o=10; undefined build -> 0.

Source files
------------

// File: rtl/urv_writeback.sv
// rtl/urv_writeback.sv - uRV writeback stage: W-stage capture, load alignment, regfile write/bypass
// Optional retired-instruction counter enabled by defining URV_WB_INSTRET_EN.
module urv_writeback (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_rd_write_i,
  input  logic        x_load_i,
  input  logic [2:0]  x_fun_i,
  input  logic [1:0]  x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  output logic [4:0]  w_rd_o,
  output logic [31:0] w_rd_value_o,
  output logic        w_rd_store_o,
  output logic        w_bypass_rd_write_o,
  output logic [31:0] w_bypass_rd_value_o,
  output logic        w_stall_req_o,
  output logic [63:0] w_instret_o
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_EXEC      = 2'd1;
  localparam logic [1:0] ST_LOAD_WAIT = 2'd2;

  logic [1:0]  state;
  logic [4:0]  w_rd;
  logic [31:0] w_value;
  logic        w_write;
  logic [2:0]  w_fun;
  logic [1:0]  w_addr;

  logic        load_done;
  logic        retire;
  logic        stall;
  logic        store;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_value;
  logic [31:0] value_out;

  always_comb begin
    ld_byte    = 8'h00;
    ld_half    = w_addr[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];
    load_value = dm_data_l_i;
    case (w_addr)
      2'd0:    ld_byte = dm_data_l_i[7:0];
      2'd1:    ld_byte = dm_data_l_i[15:8];
      2'd2:    ld_byte = dm_data_l_i[23:16];
      default: ld_byte = dm_data_l_i[31:24];
    endcase
    // LW and the unused funct3 codes fall through to the raw word.
    case (w_fun)
      3'b000:  load_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_value = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_value = {24'h000000, ld_byte};
      3'b101:  load_value = {16'h0000, ld_half};
      default: load_value = dm_data_l_i;
    endcase
  end

  assign load_done = (state == ST_LOAD_WAIT) && dm_load_done_i;
  assign retire    = !rst_i && ((state == ST_EXEC) || load_done);
  assign stall     = !rst_i && (state == ST_LOAD_WAIT) && !dm_load_done_i;
  assign store     = retire && w_write && (w_rd != 5'd0);
  assign value_out = load_done ? load_value : w_value;

  assign w_rd_o              = w_rd;
  assign w_rd_value_o        = value_out;
  assign w_rd_store_o        = store;
  assign w_bypass_rd_write_o = store;
  assign w_bypass_rd_value_o = value_out;
  assign w_stall_req_o       = stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      w_rd    <= 5'd0;
      w_value <= 32'd0;
      w_write <= 1'b0;
      w_fun   <= 3'd0;
      w_addr  <= 2'd0;
    end else if (!stall) begin
      w_rd    <= x_rd_i;
      w_value <= x_rd_value_i;
      w_write <= x_rd_write_i;
      w_fun   <= x_fun_i;
      w_addr  <= x_dm_addr_i;
      if (!x_valid_i)
        state <= ST_IDLE;
      else if (x_load_i)
        state <= ST_LOAD_WAIT;
      else
        state <= ST_EXEC;
    end
  end

`ifdef URV_WB_INSTRET_EN
  logic [63:0] instret;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      instret <= 64'd0;
    else if (retire)
      instret <= instret + 64'd1;
  end

  assign w_instret_o = instret;
`else
  assign w_instret_o = 64'd0;
`endif

endmodule

// File: tb/tb_urv_writeback.sv
// tb/tb_urv_writeback.sv - directed self-checking bench for urv_writeback
module tb_urv_writeback;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        x_valid_i;
  logic [4:0]  x_rd_i;
  logic [31:0] x_rd_value_i;
  logic        x_rd_write_i;
  logic        x_load_i;
  logic [2:0]  x_fun_i;
  logic [1:0]  x_dm_addr_i;
  logic [31:0] dm_data_l_i;
  logic        dm_load_done_i;
  logic [4:0]  w_rd_o;
  logic [31:0] w_rd_value_o;
  logic        w_rd_store_o;
  logic        w_bypass_rd_write_o;
  logic [31:0] w_bypass_rd_value_o;
  logic        w_stall_req_o;
  logic [63:0] w_instret_o;

  int n_checks = 0;
  int n_fails  = 0;
  logic [63:0] exp_ret;

  urv_writeback dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .x_valid_i           (x_valid_i),
    .x_rd_i              (x_rd_i),
    .x_rd_value_i        (x_rd_value_i),
    .x_rd_write_i        (x_rd_write_i),
    .x_load_i            (x_load_i),
    .x_fun_i             (x_fun_i),
    .x_dm_addr_i         (x_dm_addr_i),
    .dm_data_l_i         (dm_data_l_i),
    .dm_load_done_i      (dm_load_done_i),
    .w_rd_o              (w_rd_o),
    .w_rd_value_o        (w_rd_value_o),
    .w_rd_store_o        (w_rd_store_o),
    .w_bypass_rd_write_o (w_bypass_rd_write_o),
    .w_bypass_rd_value_o (w_bypass_rd_value_o),
    .w_stall_req_o       (w_stall_req_o),
    .w_instret_o         (w_instret_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_x(input logic v, input logic [4:0] rd, input logic [31:0] val,
                       input logic wr, input logic ld, input logic [2:0] fun, input logic [1:0] addr);
    x_valid_i = v; x_rd_i = rd; x_rd_value_i = val; x_rd_write_i = wr;
    x_load_i = ld; x_fun_i = fun; x_dm_addr_i = addr;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] rd, input logic st,
                         input logic [31:0] val, input logic stall);
    chk({tag, ".rd"}, 64'(w_rd_o), 64'(rd));
    chk({tag, ".store"}, 64'(w_rd_store_o), 64'(st));
    chk({tag, ".bypass_wr"}, 64'(w_bypass_rd_write_o), 64'(st));
    chk({tag, ".stall"}, 64'(w_stall_req_o), 64'(stall));
    if (st) begin
      chk({tag, ".value"}, 64'(w_rd_value_o), 64'(val));
      chk({tag, ".bypass_val"}, 64'(w_bypass_rd_value_o), 64'(val));
    end
  endtask

  task automatic chk_ret(input string tag);
`ifdef URV_WB_INSTRET_EN
    chk(tag, w_instret_o, exp_ret);
`else
    chk(tag, w_instret_o, 64'd0);
`endif
  endtask

  initial begin
    rst_i = 1'b1;
    dm_data_l_i = 32'd0;
    dm_load_done_i = 1'b0;
    exp_ret = 64'd0;
    set_x(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
    cyc();
    cyc();
    #1;
    chk_out("reset", 5'd0, 1'b0, 32'd0, 1'b0);
    chk("reset.value", 64'(w_rd_value_o), 64'd0);
    chk_ret("reset.instret");
    rst_i = 1'b0;
    cyc();

    // ALU result appears one cycle after capture
    set_x(1'b1, 5'd5, 32'h12345678, 1'b1, 1'b0, 3'd0, 2'd0);
    cyc(); #1;
    chk_out("alu", 5'd5, 1'b1, 32'h12345678, 1'b0);

    // LB sign-extend from byte 3, data arrives within the W cycle
    set_x(1'b1, 5'd3, 32'hDEAD0000, 1'b1, 1'b1, 3'b000, 2'b11);
    dm_data_l_i = 32'h80FF0000;
    cyc(); #1;
    exp_ret = 1;
    chk_out("lb.wait", 5'd3, 1'b0, 32'd0, 1'b1);
    dm_load_done_i = 1'b1;
    set_x(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
    #1;
    chk_out("lb.done", 5'd3, 1'b1, 32'hFFFFFF80, 1'b0);

    // LHU with three stall cycles; x_* changed during stall must not be captured
    set_x(1'b1, 5'd7, 32'h0, 1'b1, 1'b1, 3'b101, 2'd2);
    dm_data_l_i = 32'hBEEF1234;
    cyc();
    exp_ret = 2;
    dm_load_done_i = 1'b0;
    set_x(1'b1, 5'd9, 32'h00000055, 1'b1, 1'b0, 3'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_out($sformatf("lhu.stall%0d", i), 5'd7, 1'b0, 32'd0, 1'b1);
      if (i < 2) cyc();
    end
    dm_load_done_i = 1'b1;
    #1;
    chk_out("lhu.done", 5'd7, 1'b1, 32'h0000BEEF, 1'b0);
    cyc();
    exp_ret = 3;
    dm_load_done_i = 1'b0;
    #1;
    chk_out("after_stall", 5'd9, 1'b1, 32'h00000055, 1'b0);

    // rd=0 ALU then rd=0 load: never strobes, load still stalls
    set_x(1'b1, 5'd0, 32'h00000077, 1'b1, 1'b0, 3'd0, 2'd0);
    cyc(); #1;
    exp_ret = 4;
    chk_out("rd0.alu", 5'd0, 1'b0, 32'd0, 1'b0);
    set_x(1'b1, 5'd0, 32'd0, 1'b1, 1'b1, 3'b010, 2'd0);
    cyc(); #1;
    exp_ret = 5;
    chk_out("rd0.load.wait0", 5'd0, 1'b0, 32'd0, 1'b1);
    cyc(); #1;
    chk_out("rd0.load.wait1", 5'd0, 1'b0, 32'd0, 1'b1);
    dm_load_done_i = 1'b1;
    set_x(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
    #1;
    chk_out("rd0.load.done", 5'd0, 1'b0, 32'd0, 1'b0);
    cyc();
    exp_ret = 6;
    dm_load_done_i = 1'b0;

    // Reset during LOAD_WAIT abandons the load
    set_x(1'b1, 5'd12, 32'd0, 1'b1, 1'b1, 3'b010, 2'd0);
    dm_data_l_i = 32'h11223344;
    cyc(); #1;
    chk_out("rstload.wait", 5'd12, 1'b0, 32'd0, 1'b1);
    chk_ret("rstload.instret");
    rst_i = 1'b1;
    #1;
    chk("rstload.stall_forced", 64'(w_stall_req_o), 64'd0);
    chk("rstload.store_forced", 64'(w_rd_store_o), 64'd0);
    set_x(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
    cyc();
    rst_i = 1'b0;
    exp_ret = 0;
    dm_load_done_i = 1'b1;
    #1;
    chk_out("rstload.after", 5'd0, 1'b0, 32'd0, 1'b0);
    chk_ret("rstload.instret_clr");
    cyc(); #1;
    chk_out("rstload.done_ignored", 5'd0, 1'b0, 32'd0, 1'b0);
    dm_load_done_i = 1'b0;

    // Ten mixed instructions, two of them loads (LH upper half, misaligned LW)
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        set_x(1'b1, 5'(i + 1), 32'd0, 1'b1, 1'b1, 3'b001, 2'd2);
        dm_data_l_i = 32'h80010000;
      end else if (i == 7) begin
        set_x(1'b1, 5'(i + 1), 32'd0, 1'b1, 1'b1, 3'b010, 2'd3);
        dm_data_l_i = 32'hCAFEBABE;
      end else begin
        set_x(1'b1, 5'(i + 1), 32'(i * 17), 1'b1, 1'b0, 3'd0, 2'd0);
      end
      cyc();
      dm_load_done_i = 1'b0;
      #1;
      if (i == 3 || i == 7) begin
        chk_out($sformatf("mix%0d.wait", i), 5'(i + 1), 1'b0, 32'd0, 1'b1);
        cyc();
        dm_load_done_i = 1'b1;
        #1;
        chk_out($sformatf("mix%0d.load", i), 5'(i + 1), 1'b1,
                (i == 3) ? 32'hFFFF8001 : 32'hCAFEBABE, 1'b0);
      end else begin
        chk_out($sformatf("mix%0d.alu", i), 5'(i + 1), 1'b1, 32'(i * 17), 1'b0);
      end
    end
    set_x(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
    cyc();
    dm_load_done_i = 1'b0;
    exp_ret = 10;
    #1;
    chk_ret("mix.instret");
    chk_out("mix.idle", 5'd0, 1'b0, 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
